// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default field widths and the saturating Tnew
// decrement used by both the stage registers and the hazard unit.
package pipe_pkg;

  localparam int PIPE_ADDR_W = 5;
  localparam int PIPE_TNEW_W = 3;

  // Width-agnostic so each user can cast to its own TNEW_W.
  function automatic logic [31:0] sat_dec(input logic [31:0] x);
    return (x == 32'd0) ? 32'd0 : x - 32'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One valid/ready pipeline stage register carrying an opaque payload plus the
// register-file addresses and a self-decrementing Tnew countdown.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 64,
  parameter int ADDR_W    = PIPE_ADDR_W,
  parameter int TNEW_W    = PIPE_TNEW_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [ADDR_W-1:0]    in_a1,
  input  logic [ADDR_W-1:0]    in_a2,
  input  logic [ADDR_W-1:0]    in_a3,
  input  logic                 in_rfen,
  input  logic [TNEW_W-1:0]    in_tnew,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [ADDR_W-1:0]    out_a1,
  output logic [ADDR_W-1:0]    out_a2,
  output logic [ADDR_W-1:0]    out_a3,
  output logic                 out_rfen,
  output logic [TNEW_W-1:0]    out_tnew
);

  logic                 valid_q,   valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [ADDR_W-1:0]    a1_q,      a1_d;
  logic [ADDR_W-1:0]    a2_q,      a2_d;
  logic [ADDR_W-1:0]    a3_q,      a3_d;
  logic                 rfen_q,    rfen_d;
  logic [TNEW_W-1:0]    tnew_q,    tnew_d;
  logic                 load;

  assign in_ready = !flush && (!valid_q || out_ready);
  assign load     = in_valid && in_ready;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    a3_d      = a3_q;
    rfen_d    = rfen_q;
    tnew_d    = tnew_q;
    if (flush) begin
      valid_d = 1'b0;
      tnew_d  = '0;
    end else if (load) begin
      // Covers both fill-from-empty and the zero-bubble pop+load case.
      valid_d   = 1'b1;
      payload_d = in_payload;
      a1_d      = in_a1;
      a2_d      = in_a2;
      a3_d      = in_a3;
      rfen_d    = in_rfen;
      tnew_d    = TNEW_W'(sat_dec(32'(in_tnew)));
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      tnew_d = TNEW_W'(sat_dec(32'(tnew_q)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      a3_q      <= '0;
      rfen_q    <= 1'b0;
      tnew_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      a1_q      <= a1_d;
      a2_q      <= a2_d;
      a3_q      <= a3_d;
      rfen_q    <= rfen_d;
      tnew_q    <= tnew_d;
    end
  end

  // An empty stage must look like a harmless bubble to the hazard unit;
  // payload is left as-is since nothing downstream decodes it without valid.
  assign out_valid   = valid_q;
  assign out_payload = payload_q;
  assign out_a1      = valid_q ? a1_q   : '0;
  assign out_a2      = valid_q ? a2_q   : '0;
  assign out_a3      = valid_q ? a3_q   : '0;
  assign out_rfen    = valid_q ? rfen_q : 1'b0;
  assign out_tnew    = valid_q ? tnew_q : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios followed by a
// randomized run, all compared against a behavioural occupancy model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_payload;
  logic [4:0]  in_a1, in_a2, in_a3;
  logic        in_rfen;
  logic [2:0]  in_tnew;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_payload;
  logic [4:0]  out_a1, out_a2, out_a3;
  logic        out_rfen;
  logic [2:0]  out_tnew;

  int checks = 0;
  int errors = 0;

  // Behavioural model: "is there an instruction in the stage, and what is it"
  bit          m_valid;
  logic [63:0] m_payload;
  logic [4:0]  m_a1, m_a2, m_a3;
  logic        m_rfen;
  int          m_tnew;

  pipe_stage_reg #(.PAYLOAD_W(64), .ADDR_W(5), .TNEW_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3), .in_rfen(in_rfen),
    .in_tnew(in_tnew),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_a1(out_a1), .out_a2(out_a2), .out_a3(out_a3), .out_rfen(out_rfen),
    .out_tnew(out_tnew)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return !flush && (!m_valid || out_ready);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_payload = '0; m_a1 = '0; m_a2 = '0; m_a3 = '0;
    m_rfen = 0; m_tnew = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"},   64'(out_valid),   64'(m_valid));
    chk({tag, ".in_ready"},    64'(in_ready),    64'(model_ready()));
    chk({tag, ".out_payload"}, out_payload,      m_payload);
    chk({tag, ".out_a1"},      64'(out_a1),      m_valid ? 64'(m_a1) : 64'd0);
    chk({tag, ".out_a2"},      64'(out_a2),      m_valid ? 64'(m_a2) : 64'd0);
    chk({tag, ".out_a3"},      64'(out_a3),      m_valid ? 64'(m_a3) : 64'd0);
    chk({tag, ".out_rfen"},    64'(out_rfen),    m_valid ? 64'(m_rfen) : 64'd0);
    chk({tag, ".out_tnew"},    64'(out_tnew),    m_valid ? 64'(m_tnew) : 64'd0);
  endtask

  // Advance one clock; the model decides the next contents from the inputs
  // present before the edge, outputs are sampled 1 time unit after it.
  task automatic tick(input string tag);
    bit          n_valid;
    logic [63:0] n_payload;
    logic [4:0]  n_a1, n_a2, n_a3;
    logic        n_rfen;
    int          n_tnew;
    n_valid = m_valid; n_payload = m_payload; n_a1 = m_a1; n_a2 = m_a2;
    n_a3 = m_a3; n_rfen = m_rfen; n_tnew = m_tnew;
    if (flush) begin
      n_valid = 0; n_tnew = 0;
    end else if (in_valid && model_ready()) begin
      n_valid = 1; n_payload = in_payload; n_a1 = in_a1; n_a2 = in_a2;
      n_a3 = in_a3; n_rfen = in_rfen;
      n_tnew = (int'(in_tnew) > 0) ? int'(in_tnew) - 1 : 0;
    end else if (m_valid && out_ready) begin
      n_valid = 0;
    end else if (m_valid) begin
      n_tnew = (m_tnew > 0) ? m_tnew - 1 : 0;
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_payload = n_payload; m_a1 = n_a1; m_a2 = n_a2;
    m_a3 = n_a3; m_rfen = n_rfen; m_tnew = n_tnew;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input logic [63:0] p, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] a3,
                       input bit rf, input logic [2:0] tn);
    in_valid = v; in_payload = p; in_a1 = a1; in_a2 = a2; in_a3 = a3;
    in_rfen = rf; in_tnew = tn;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1, 64'hAA, 5'd1, 5'd2, 5'd5, 1, 3'd4);
    model_reset();

    // Reset held with a valid input present
    @(posedge clk); @(posedge clk); #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_a3",    64'(out_a3),    64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    check_all("rst");
    reset_n = 1'b1;
    #1;
    tick("rst_release");
    chk("rst_release.out_valid", 64'(out_valid), 64'd1);
    chk("rst_release.out_a3",    64'(out_a3),    64'd5);

    // Drain, then Tnew countdown with saturating floor
    in_valid = 0; out_ready = 1;
    tick("drain0");
    drive(1, 64'h33, 5'd3, 5'd4, 5'd6, 1, 3'd3); out_ready = 0;
    tick("tnew_load");
    chk("tnew.c0", 64'(out_tnew), 64'd2);
    in_valid = 0;
    tick("tnew_hold1"); chk("tnew.c1", 64'(out_tnew), 64'd1);
    tick("tnew_hold2"); chk("tnew.c2", 64'(out_tnew), 64'd0);
    tick("tnew_hold3"); chk("tnew.c3", 64'(out_tnew), 64'd0);

    // Back-to-back streaming
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      drive(1, 64'(i), 5'(i), 5'(i + 1), 5'(i + 2), i[0], 3'(i));
      #1;
      chk("stream.in_ready", 64'(in_ready), 64'd1);
      tick("stream");
      chk("stream.payload", out_payload, 64'(i));
      chk("stream.valid",   64'(out_valid), 64'd1);
    end

    // Backpressure then release
    drive(1, 64'hB0B0, 5'd9, 5'd10, 5'd11, 1, 3'd2); out_ready = 0;
    #1;
    chk("bp.in_ready_lo", 64'(in_ready), 64'd0);
    tick("bp_hold");
    chk("bp.payload_held", out_payload, 64'd8);
    out_ready = 1;
    #1;
    chk("bp.in_ready_hi", 64'(in_ready), 64'd1);
    tick("bp_release");
    chk("bp.payload_new", out_payload, 64'hB0B0);

    // Flush beats load and pop
    flush = 1; drive(1, 64'hF1F1, 5'd7, 5'd7, 5'd7, 1, 3'd7);
    #1;
    chk("flush.in_ready", 64'(in_ready), 64'd0);
    tick("flush");
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    chk("flush.out_a1",    64'(out_a1),    64'd0);
    chk("flush.out_tnew",  64'(out_tnew),  64'd0);
    chk("flush.out_rfen",  64'(out_rfen),  64'd0);
    flush = 0;

    // Asynchronous reset while holding
    drive(1, 64'hC0DE, 5'd12, 5'd13, 5'd14, 1, 3'd5); out_ready = 0;
    tick("hold_fill");
    in_valid = 0;
    tick("hold");
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst.out_valid", 64'(out_valid), 64'd0);
    chk("async_rst.out_a3",    64'(out_a3),    64'd0);
    chk("async_rst.payload",   out_payload,    64'd0);
    model_reset();
    #1 reset_n = 1'b1;
    tick("post_rst_empty");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      flush     = ($urandom_range(0, 7) == 0);
      out_ready = $urandom_range(0, 2) != 0;
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, 5'($urandom),
            5'($urandom), 5'($urandom), 1'($urandom), 3'($urandom));
      #1;
      chk("rand.in_ready", 64'(in_ready), 64'(model_ready()));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter PAYLOAD_W, default 64, giving the width of the opaque control/data bundle carried through the stage.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the width of the register-file address fields.
REQ-003 The block SHALL have parameter TNEW_W, default 3, giving the width of the Tnew (cycles-until-result) field.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port flush, input, 1 bit, which inserts a bubble at the next edge.
REQ-008 The block SHALL have port in_valid, input, 1 bit, which marks an upstream instruction as present.
REQ-009 The block SHALL have port in_ready, output, 1 bit, which means the stage accepts this cycle.
REQ-010 The block SHALL have input ports in_payload (PAYLOAD_W), in_a1, in_a2 and in_a3 (ADDR_W each), in_rfen (1 bit) and in_tnew (TNEW_W), carrying the upstream instruction fields.
REQ-011 The block SHALL have port out_valid, output, 1 bit, which marks the stage as occupied.
REQ-012 The block SHALL have port out_ready, input, 1 bit, which means downstream takes the contents this cycle.
REQ-013 The block SHALL have output ports out_payload, out_a1, out_a2, out_a3, out_rfen and out_tnew, with the same widths as their inputs, carrying the stage contents.

Function
REQ-014 The block SHALL drive in_ready = !flush && (!out_valid || out_ready) combinationally, and in_ready SHALL NOT depend on in_valid.
REQ-015 The block SHALL define load as in_valid && in_ready; on a load edge it SHALL capture all in_* fields and set out_valid to 1.
REQ-016 On a load edge the block SHALL store tnew_q = sat_dec(in_tnew), where sat_dec(0) = 0 and otherwise sat_dec(x) = x-1.
REQ-017 While out_valid=1 and out_ready=0 with no flush, the block SHALL hold payload and addresses and SHALL update tnew_q to sat_dec(tnew_q) every cycle.
REQ-018 When out_valid=1, out_ready=1 and there is no load, the block SHALL clear out_valid to 0 at the edge.
REQ-019 When out_ready=1 and load occur in the same cycle, the block SHALL replace its contents with the new fields and keep out_valid at 1 (full throughput, zero-bubble).
REQ-020 When flush=1, the block SHALL clear out_valid and tnew_q at the edge, and flush SHALL take priority over load, hold and pop.
REQ-021 When out_valid=0, the block SHALL force out_a1, out_a2, out_a3, out_tnew and out_rfen to 0; out_payload SHALL keep its last captured value.
REQ-022 When out_valid=1, the block SHALL drive out_tnew = tnew_q and all other out_* fields from their registers.
REQ-023 The block SHALL have a latency of one cycle from a load edge to out_valid=1.
REQ-024 The block SHALL perform no combinational path from in_* data to out_* data.

Reset
REQ-025 While reset_n=0, asynchronously, the block SHALL set out_valid=0, tnew_q=0 and all captured fields to 0, so every output reads 0 and in_ready follows REQ-014 (1 unless flush).
REQ-026 If reset is asserted mid-hold, the block SHALL discard the held instruction, and the first edge after reset_n rises SHALL behave as from an empty stage.

Structure
REQ-027 Package pipe_pkg SHALL hold the ADDR_W/TNEW_W defaults and the sat_dec function, shared with the hazard unit.
REQ-028 The block SHALL have no sub-module; the stage is one flat register with next-state logic, and a pipeline SHALL be built by chaining instances.

Verification
REQ-029 The bench SHALL cover reset: hold reset_n=0 with in_valid=1 and in_a3=5 -> out_valid=0, out_a3=0, in_ready=1; release, one edge -> out_valid=1, out_a3=5.
REQ-030 The bench SHALL cover Tnew decrement: load in_tnew=3 with out_ready=0 for 4 cycles -> out_tnew 2,1,0,0, with the saturating floor holding at 0.
REQ-031 The bench SHALL cover back-to-back streaming: in_valid=1 and out_ready=1 for 8 cycles with payloads 1..8 -> out_payload 1..8 on consecutive cycles with in_ready always 1.
REQ-032 The bench SHALL cover backpressure: out_valid=1, out_ready=0, in_valid=1 -> in_ready=0 and payload unchanged; raising out_ready -> new payload loaded on that edge.
REQ-033 The bench SHALL cover flush priority: flush=1, in_valid=1 and out_ready=1 together -> out_valid=0, in_ready=0, and out_a1/a2/a3/rfen/tnew all 0 next cycle.
REQ-034 The bench SHALL cover async reset mid-hold: assert reset_n=0 between clock edges -> out_valid falls immediately without waiting for clk.
